// File: rtl/image_bram_arbiter.sv
// Shares the single-port image BRAM between the LCD read stream (req 0) and the image writer (req 1).
// Bounded-burst round-robin grant, registered BRAM drive, fixed-latency registered read return.
module image_bram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_wdata_o,
  input  logic [DATA_W-1:0] bram_rdata_i,
  output logic              conflict_o
);

  localparam int                CNT_W   = 8;
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);
  localparam int                PIPE_D  = 1 + RD_LATENCY;

  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_both;
  logic              w_pick_wr;
  logic              w_rd_gnt;
  logic              w_wr_gnt;
  logic              w_any_gnt;

  logic              r_bram_en;
  logic              r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_wdata;
  logic [PIPE_D-1:0] r_vld_pipe;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_conflict;

  assign w_both    = rd_req_i && wr_req_i;
  // Under contention stay with the last owner until its burst budget is spent.
  assign w_pick_wr = (r_cnt < MAX_CNT) ? r_last : !r_last;

  always_comb begin
    w_rd_gnt = 1'b0;
    w_wr_gnt = 1'b0;
    if (!rst_i) begin
      if (w_both) begin
        w_wr_gnt = w_pick_wr;
        w_rd_gnt = !w_pick_wr;
      end else begin
        w_rd_gnt = rd_req_i;
        w_wr_gnt = wr_req_i;
      end
    end
  end

  assign w_any_gnt = w_rd_gnt || w_wr_gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else if (w_any_gnt) begin
      if (w_wr_gnt == r_last) begin
        if (r_cnt < MAX_CNT) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_last <= w_wr_gnt;
        r_cnt  <= CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_conflict   <= 1'b0;
    end else begin
      r_bram_en  <= w_any_gnt;
      r_bram_we  <= w_wr_gnt;
      r_conflict <= w_both;
      if (w_wr_gnt) begin
        r_bram_addr  <= wr_addr_i;
        r_bram_wdata <= wr_data_i;
      end else if (w_rd_gnt) begin
        r_bram_addr  <= rd_addr_i;
      end
    end
  end

  // Stage k of the pipe lines up with the BRAM access k cycles after it was driven.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[PIPE_D-2:0], w_rd_gnt};
      r_rd_valid <= r_vld_pipe[PIPE_D-1];
      if (r_vld_pipe[PIPE_D-1]) begin
        r_rd_data <= bram_rdata_i;
      end
    end
  end

  assign rd_gnt_o     = w_rd_gnt;
  assign wr_gnt_o     = w_wr_gnt;
  assign bram_en_o    = r_bram_en;
  assign bram_we_o    = r_bram_we;
  assign bram_addr_o  = r_bram_addr;
  assign bram_wdata_o = r_bram_wdata;
  assign rd_valid_o   = r_rd_valid;
  assign rd_data_o    = r_rd_data;
  assign conflict_o   = r_conflict;

endmodule

// File: tb/tb_image_bram_arbiter.sv
// Bench for image_bram_arbiter: three instances (default, RD_LATENCY=2, MAX_BURST=1),
// directed stimulus pushing expectations into queues that a negedge monitor drains.
module tb_image_bram_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 16;
  localparam int NDUT = 3;

  localparam int K_RDG  = 0;
  localparam int K_WRG  = 1;
  localparam int K_EN   = 2;
  localparam int K_WE   = 3;
  localparam int K_ADDR = 4;
  localparam int K_WDAT = 5;
  localparam int K_RDV  = 6;
  localparam int K_CONF = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NDUT-1:0]   rd_req, wr_req;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NDUT-1:0]   rd_gnt, wr_gnt, rd_valid, bram_en, bram_we, conflict;
  logic [DW-1:0]     rd_data    [NDUT];
  logic [AW-1:0]     bram_addr  [NDUT];
  logic [DW-1:0]     bram_wdata [NDUT];
  logic [DW-1:0]     bram_rdata [NDUT];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int RLG = (g == 1) ? 2 : 1;
    localparam int MBG = (g == 2) ? 1 : 8;
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rq1, rq2;
    always @(posedge clk) begin
      if (bram_en[g]) begin
        if (bram_we[g]) mem[bram_addr[g]] <= bram_wdata[g];
        else            rq1 <= mem[bram_addr[g]];
      end
      rq2 <= rq1;
    end
    assign bram_rdata[g] = (RLG == 2) ? rq2 : rq1;

    image_bram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RLG), .MAX_BURST(MBG)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .rd_req_i(rd_req[g]), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt[g]),
      .rd_data_o(rd_data[g]), .rd_valid_o(rd_valid[g]),
      .wr_req_i(wr_req[g]), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt[g]),
      .bram_en_o(bram_en[g]), .bram_we_o(bram_we[g]), .bram_addr_o(bram_addr[g]),
      .bram_wdata_o(bram_wdata[g]), .bram_rdata_i(bram_rdata[g]),
      .conflict_o(conflict[g])
    );
  end

  typedef struct { int g; int kind; int val; int at; } probe_t;
  typedef struct { int g; int data; int at; } rdexp_t;
  probe_t probe_q[$];
  rdexp_t rd_q[$];
  bit     done = 1'b0;

  function automatic int rl(int g);  return (g == 1) ? 2 : 1; endfunction
  function automatic int mb(int g);  return (g == 2) ? 1 : 8; endfunction

  function automatic string kname(int k);
    case (k)
      K_RDG:   return "rd_gnt";
      K_WRG:   return "wr_gnt";
      K_EN:    return "bram_en";
      K_WE:    return "bram_we";
      K_ADDR:  return "bram_addr";
      K_WDAT:  return "bram_wdata";
      K_RDV:   return "rd_valid";
      default: return "conflict";
    endcase
  endfunction

  function automatic int actual(int g, int k);
    case (k)
      K_RDG:   return int'(rd_gnt[g]);
      K_WRG:   return int'(wr_gnt[g]);
      K_EN:    return int'(bram_en[g]);
      K_WE:    return int'(bram_we[g]);
      K_ADDR:  return int'(bram_addr[g]);
      K_WDAT:  return int'(bram_wdata[g]);
      K_RDV:   return int'(rd_valid[g]);
      default: return int'(conflict[g]);
    endcase
  endfunction

  // Monitor / scoreboard
  int checks = 0;
  int fails  = 0;
  always @(negedge clk) begin
    int idx;
    for (int i = probe_q.size() - 1; i >= 0; i--) begin
      if (probe_q[i].at <= cyc) begin
        checks++;
        if (probe_q[i].at < cyc || actual(probe_q[i].g, probe_q[i].kind) != probe_q[i].val) begin
          fails++;
          $display("FAIL %s dut%0d cyc %0d: got %0h, required %0h (due cyc %0d)",
                   kname(probe_q[i].kind), probe_q[i].g, cyc,
                   actual(probe_q[i].g, probe_q[i].kind), probe_q[i].val, probe_q[i].at);
        end
        probe_q.delete(i);
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      if (rd_valid[g]) begin
        idx = -1;
        for (int i = 0; i < rd_q.size(); i++) begin
          if (idx < 0 && rd_q[i].g == g) idx = i;
        end
        checks++;
        if (idx < 0) begin
          fails++;
          $display("FAIL rd_spurious dut%0d cyc %0d: got valid data %0h, required no valid", g, cyc, rd_data[g]);
        end else begin
          if (rd_q[idx].at != cyc || int'(rd_data[g]) != rd_q[idx].data) begin
            fails++;
            $display("FAIL rd_return dut%0d: got data %0h at cyc %0d, required %0h at cyc %0d",
                     g, rd_data[g], cyc, rd_q[idx].data, rd_q[idx].at);
          end
          rd_q.delete(idx);
        end
      end
    end
    for (int i = rd_q.size() - 1; i >= 0; i--) begin
      if (rd_q[i].at < cyc) begin
        checks++;
        fails++;
        $display("FAIL rd_missing dut%0d: got no valid by cyc %0d, required data %0h at cyc %0d",
                 rd_q[i].g, cyc, rd_q[i].data, rd_q[i].at);
        rd_q.delete(i);
      end
    end
    if (done || cyc > 20000) begin
      if (!done) begin
        fails++;
        $display("FAIL timeout: got cyc %0d, required stimulus done", cyc);
      end
      fails  += probe_q.size() + rd_q.size();
      checks += probe_q.size() + rd_q.size();
      if (probe_q.size() + rd_q.size() != 0)
        $display("FAIL leftover: got %0d unchecked expectations, required 0", probe_q.size() + rd_q.size());
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
    end
  end

  // Stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int g, input int kind, input int val, input int at);
    probe_q.push_back('{g, kind, val, at});
  endtask

  task automatic exp_rd(input int g, input int data, input int at);
    rd_q.push_back('{g, data, at});
  endtask

  task automatic idle();
    rd_req = '0;
    wr_req = '0;
  endtask

  typedef struct { bit rd; bit wr; int exp; int n; } ph_t;

  int     shadow [NDUT];
  bit     is_wr;
  ph_t    ph [6];

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) step();
    rst = 1'b0;

    // Preload 0x0005=0x1234 and 0x0100=0x0A0A through the write port
    step();
    wr_req = '1; wr_addr = 14'h0005; wr_data = 16'h1234;
    for (int g = 0; g < NDUT; g++) begin
      probe(g, K_WRG, 1, cyc);
      probe(g, K_EN, 1, cyc + 1);
      probe(g, K_WE, 1, cyc + 1);
      probe(g, K_ADDR, 'h0005, cyc + 1);
      probe(g, K_WDAT, 'h1234, cyc + 1);
    end
    step();
    wr_addr = 14'h0100; wr_data = 16'h0A0A;
    for (int g = 0; g < NDUT; g++) probe(g, K_WRG, 1, cyc);
    step();
    idle();
    for (int g = 0; g < NDUT; g++) begin
      probe(g, K_EN, 0, cyc + 1);
      shadow[g] = 'h0A0A;
    end

    // Reset held 4 cycles with both requests high
    for (int k = 0; k < 4; k++) begin
      step();
      rst = 1'b1; rd_req = '1; wr_req = '1;
      for (int g = 0; g < NDUT; g++) begin
        probe(g, K_RDG, 0, cyc);
        probe(g, K_WRG, 0, cyc);
        probe(g, K_EN, 0, cyc + 1);
        probe(g, K_RDV, 0, cyc + 1);
        probe(g, K_CONF, 0, cyc + 1);
      end
    end

    // Contention: 40 cycles, same address so reads observe the latest write
    for (int i = 0; i < 40; i++) begin
      step();
      rst = 1'b0; rd_req = '1; wr_req = '1;
      rd_addr = 14'h0100; wr_addr = 14'h0100; wr_data = 16'h1000 + 16'(i);
      for (int g = 0; g < NDUT; g++) begin
        is_wr = ((i / mb(g)) % 2) == 1;
        probe(g, K_RDG, int'(!is_wr), cyc);
        probe(g, K_WRG, int'(is_wr), cyc);
        probe(g, K_EN, 1, cyc + 1);
        probe(g, K_WE, int'(is_wr), cyc + 1);
        if (i > 0) probe(g, K_CONF, 1, cyc);
        if (is_wr) shadow[g] = 'h1000 + i;
        else       exp_rd(g, shadow[g], cyc + 2 + rl(g));
      end
    end
    step();
    idle();
    for (int g = 0; g < NDUT; g++) begin
      probe(g, K_RDG, 0, cyc);
      probe(g, K_WRG, 0, cyc);
      probe(g, K_CONF, 1, cyc);
      probe(g, K_CONF, 0, cyc + 1);
      probe(g, K_EN, 0, cyc + 1);
    end
    repeat (6) step();

    // Single read of 0x0005 on the RD_LATENCY=1 and =2 instances
    step();
    rd_req = 3'b011; rd_addr = 14'h0005;
    for (int g = 0; g < 2; g++) begin
      probe(g, K_RDG, 1, cyc);
      probe(g, K_EN, 1, cyc + 1);
      probe(g, K_WE, 0, cyc + 1);
      probe(g, K_ADDR, 'h0005, cyc + 1);
      probe(g, K_WDAT, 'h101F, cyc + 1);
      exp_rd(g, 'h1234, cyc + 2 + rl(g));
    end
    step();
    idle();
    for (int g = 0; g < 2; g++) probe(g, K_EN, 0, cyc + 1);
    repeat (6) step();

    // Read-after-write at the top address
    step();
    wr_req = '1; wr_addr = 14'h3FFF; wr_data = 16'hBEEF;
    for (int g = 0; g < NDUT; g++) begin
      probe(g, K_WRG, 1, cyc);
      probe(g, K_ADDR, 'h3FFF, cyc + 1);
      probe(g, K_WE, 1, cyc + 1);
    end
    step();
    wr_req = '0; wr_data = 16'h0000; rd_req = '1; rd_addr = 14'h3FFF;
    for (int g = 0; g < NDUT; g++) begin
      probe(g, K_RDG, 1, cyc);
      probe(g, K_ADDR, 'h3FFF, cyc + 1);
      probe(g, K_WE, 0, cyc + 1);
      probe(g, K_WDAT, 'hBEEF, cyc + 1);
      exp_rd(g, 'hBEEF, cyc + 2 + rl(g));
    end
    step();
    idle();
    repeat (6) step();

    // Reset one cycle after four back-to-back reads: only reads already returning survive
    for (int k = 0; k < 4; k++) begin
      step();
      rd_req = 3'b011; rd_addr = 14'h0005;
      probe(0, K_RDG, 1, cyc);
      probe(1, K_RDG, 1, cyc);
      if (k < 2)  exp_rd(0, 'h1234, cyc + 3);
      if (k == 0) exp_rd(1, 'h1234, cyc + 4);
    end
    step();
    idle();
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      probe(g, K_RDG, 0, cyc);
      probe(g, K_EN, 0, cyc + 1);
      for (int d = 1; d <= 4; d++) probe(g, K_RDV, 0, cyc + d);
    end
    step();
    rst = 1'b0;
    repeat (6) step();

    // Burst break on the default instance: rd, wr, expected grant (1=rd, 2=wr), cycles
    ph = '{'{1'b0, 1'b1, 2, 5}, '{1'b1, 1'b1, 2, 3}, '{1'b1, 1'b1, 1, 8},
           '{1'b1, 1'b1, 2, 2}, '{1'b1, 1'b0, 1, 1}, '{1'b0, 1'b1, 2, 3}};
    rd_addr = 14'h0005; wr_addr = 14'h0200; wr_data = 16'h5555;
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < ph[p].n; n++) begin
        step();
        rd_req = {2'b00, ph[p].rd};
        wr_req = {2'b00, ph[p].wr};
        probe(0, K_RDG, int'(ph[p].exp == 1), cyc);
        probe(0, K_WRG, int'(ph[p].exp == 2), cyc);
        if (ph[p].exp == 1) exp_rd(0, 'h1234, cyc + 3);
      end
    end
    // Writer owns the slot with budget left; after reset contention must go to read
    step();
    rst = 1'b1; rd_req = 3'b001; wr_req = 3'b001;
    probe(0, K_RDG, 0, cyc);
    probe(0, K_WRG, 0, cyc);
    step();
    rst = 1'b0;
    probe(0, K_RDG, 1, cyc);
    probe(0, K_WRG, 0, cyc);
    exp_rd(0, 'h1234, cyc + 3);
    step();
    idle();
    repeat (6) step();
    done = 1'b1;
  end

endmodule

// File: doc/image_bram_arbiter.md
Name: image_bram_arbiter

Overview:
- Shares the single-port image BRAM between two requesters:
  - display read stream (LCD refresh, requester 0);
  - image update writer (SPI/host loader, requester 1).
- Grants with bounded-burst round-robin and drives the BRAM port from a registered stage.
- Returns read data with a fixed, parameterised latency.
- Sits between the LCD pixel fetcher / image loader and the image_bram instance.

Parameters:
- ADDR_W, 14, BRAM word address width (128x128 pixels).
- DATA_W, 16, pixel word width (RGB565).
- RD_LATENCY, 1, BRAM read latency in cycles from bram_en_o to valid bram_rdata_i; legal values 1 or 2.
- MAX_BURST, 8, maximum consecutive grants to one requester while the other is requesting; legal values 1..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- rd_req_i  in  1  read request; held until granted
- rd_addr_i  in  ADDR_W  read address, valid with rd_req_i
- rd_gnt_o  out  1  read accepted this cycle (combinational)
- rd_data_o  out  DATA_W  returned read word (registered)
- rd_valid_o  out  1  rd_data_o valid, single-cycle pulse per accepted read
- wr_req_i  in  1  write request; held until granted
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- wr_gnt_o  out  1  write accepted this cycle (combinational)
- bram_en_o  out  1  BRAM enable (registered)
- bram_we_o  out  1  BRAM write enable (registered)
- bram_addr_o  out  ADDR_W  BRAM address (registered)
- bram_wdata_o  out  DATA_W  BRAM write data (registered)
- bram_rdata_i  in  DATA_W  BRAM read data
- conflict_o  out  1  registered pulse: both requested and one was denied in the previous cycle

Behaviour:
- Reset values, held while rst_i=1: all outputs 0; rd_gnt_o=wr_gnt_o=0; last_q=0 (read); cnt_q=0; read-valid pipeline cleared.
- Transfer rule: a transfer occurs in a cycle where req && gnt. Address and data are sampled at that clock edge. The requester may change address, data or deassert afterwards. Grants are never issued without a request.
- Grant logic is combinational from rd_req_i, wr_req_i, last_q and cnt_q. At most one grant per cycle.
  - Only one request: grant it.
  - Both requests, cnt_q < MAX_BURST: grant the requester indicated by last_q.
  - Both requests, cnt_q >= MAX_BURST: grant the other requester.
- Arbitration state update:
  - Granted requester equals last_q: cnt_q <= cnt_q+1, saturating at MAX_BURST.
  - Granted requester differs from last_q: last_q <= granted, cnt_q <= 1.
  - No request this cycle: cnt_q <= 0, last_q held.
- BRAM drive stage. Grant in cycle N produces in cycle N+1:
  - bram_en_o=1;
  - bram_we_o=1 for a write, 0 for a read;
  - bram_addr_o = the granted address;
  - bram_wdata_o = wr_data_i for a write; holds its previous value for a read.
  - With no grant in cycle N: bram_en_o=0 and bram_we_o=0 in N+1; address and data hold.
- Read return:
  - bram_rdata_i is sampled at the end of cycle N+1+RD_LATENCY.
  - rd_data_o and rd_valid_o are registered, visible in cycle N+2+RD_LATENCY. Total grant-to-valid latency is 3 cycles at default.
  - A shift-register valid pipeline of depth 1+RD_LATENCY tracks in-flight reads.
  - Back-to-back reads give back-to-back rd_valid_o pulses in grant order.
  - rd_data_o holds its value when rd_valid_o=0.
- Ordering: BRAM accesses issue strictly in grant order.
  - A write granted in N followed by a read of the same address granted in N+1 returns the new data (single-port, write-first not required because the accesses are serialised).
- conflict_o: registered. It is 1 in cycle N+1 iff rd_req_i && wr_req_i were both high in cycle N.
- Reset mid-operation:
  - In-flight reads are discarded; rd_valid_o=0 from the first cycle rst_i is sampled high.
  - BRAM enables drop in that same cycle.
  - No grants are issued while rst_i=1.
  - Arbitration restarts with read priority.
- Boundary cases:
  - MAX_BURST=1 gives strict alternation under contention.
  - A requester that deasserts mid-burst lets the other be granted immediately.
  - Address wrap is the requesters' responsibility; the block passes addresses through unmodified.

Test Plan:
- Reset: hold rst_i 4 cycles with both requests high -> no grants, bram_en_o=0, rd_valid_o=0. First cycle after release grants read (last_q=0).
- Single read at addr 0x0005, memory word 0x1234 -> bram_en_o=1, bram_we_o=0, bram_addr_o=0x0005 one cycle after grant. rd_valid_o=1 with rd_data_o=0x1234 exactly 3 cycles after grant (RD_LATENCY=1). Repeat with RD_LATENCY=2 -> 4 cycles.
- Contention with rd_req_i and wr_req_i held high 40 cycles, MAX_BURST=8 -> grant pattern 8 reads, 8 writes, 8 reads, ... with no idle slots. conflict_o high from cycle 2 onward. Repeat with MAX_BURST=1 -> strict R,W,R,W.
- Read-after-write: write 0xBEEF to 0x3FFF in cycle N, read 0x3FFF in N+1 -> rd_data_o=0xBEEF. Also confirm the top address is passed unmodified.
- Reset mid-stream: 4 reads granted back-to-back, assert rst_i 1 cycle after the last grant -> zero rd_valid_o pulses for the discarded reads. Arbitration state cleared.
- Burst break: writer requests alone for 5 grants, then the reader joins -> writer keeps the grant for 3 more cycles (cnt 6..8), then the reader is granted. Writer drops early -> reader granted the same cycle.
